// File: rtl/hazard_forward_unit.sv
// Operand forwarding and hazard detection between decode and EX, with a per-register scoreboard
// for long-latency producers. Optional stall counter output is enabled by HAZ_STALL_CNT_EN.
module hazard_forward_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LONG_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   id_src_data,
  input  logic [REG_AW-1:0]           id_dest,
  input  logic                        id_wr_en,
  input  logic [REG_AW-1:0]           ex_dest,
  input  logic                        ex_wr_en,
  input  logic                        ex_long,
  input  logic [DATA_W-1:0]           ex_data,
  input  logic [REG_AW-1:0]           wb_dest,
  input  logic                        wb_wr_en,
  input  logic [DATA_W-1:0]           wb_data,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic                        stall,
  output logic                        busy
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(LONG_LAT + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_WB = 2'd1;
  localparam logic [1:0] SEL_EX = 2'd2;

  if (LONG_LAT < 2 || LONG_LAT > 15) begin : g_bad_lat
    $error("hazard_forward_unit: LONG_LAT must be within 2..15");
  end

  logic [CNT_W-1:0] r_cnt [NREG];

  logic w_ex_long_wr;
  logic w_ex_fwd_ok;
  logic w_src_hazard;
  logic w_waw_hazard;

  assign w_ex_long_wr = ex_wr_en & ex_long;
  assign w_ex_fwd_ok  = ex_wr_en & ~ex_long;

  // Long issue reloads the counter; otherwise pending counters count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_ex_long_wr && (ex_dest == REG_AW'(r))) begin
          r_cnt[r] <= CNT_LOAD;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    fwd_data = '0;
    fwd_sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_data[i*DATA_W +: DATA_W] = id_src_data[i*DATA_W +: DATA_W];
      fwd_sel[2*i +: 2]            = SEL_RF;
      if (id_src_used[i]) begin
        if (w_ex_fwd_ok && (ex_dest == id_src_addr[i*REG_AW +: REG_AW])) begin
          fwd_data[i*DATA_W +: DATA_W] = ex_data;
          fwd_sel[2*i +: 2]            = SEL_EX;
        end else if (wb_wr_en && (wb_dest == id_src_addr[i*REG_AW +: REG_AW])) begin
          fwd_data[i*DATA_W +: DATA_W] = wb_data;
          fwd_sel[2*i +: 2]            = SEL_WB;
        end
      end
    end
  end

  // A counter of 1 means the result is on the WB bus this cycle, so only >= 2 blocks.
  always_comb begin
    w_src_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        if (w_ex_long_wr && (ex_dest == id_src_addr[i*REG_AW +: REG_AW])) begin
          w_src_hazard = 1'b1;
        end
        if (r_cnt[id_src_addr[i*REG_AW +: REG_AW]] >= CNT_TWO) begin
          w_src_hazard = 1'b1;
        end
      end
    end
  end

  assign w_waw_hazard = id_wr_en &
                        ((r_cnt[id_dest] >= CNT_TWO) | (w_ex_long_wr & (ex_dest == id_dest)));

  assign stall = w_src_hazard | w_waw_hazard;

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (r_cnt[r] != '0) begin
        busy = 1'b1;
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed table, hand-written multi-cycle sequences
// and randomized traffic checked against a ready-time model of the scoreboard.
module tb_hazard_forward_unit;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned NS   = 2;
  localparam int unsigned LAT  = 3;
  localparam int          NREG = 16;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NS*AW-1:0]  src_addr;
  logic [NS-1:0]     src_used;
  logic [NS*DW-1:0]  src_data;
  logic [AW-1:0]     id_dest;
  logic              id_wr_en;
  logic [AW-1:0]     ex_dest;
  logic              ex_wr_en;
  logic              ex_long;
  logic [DW-1:0]     ex_data;
  logic [AW-1:0]     wb_dest;
  logic              wb_wr_en;
  logic [DW-1:0]     wb_data;
  logic [NS*DW-1:0]  fwd_data;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall;
  logic              busy;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  hazard_forward_unit #(
    .DATA_W   (DW),
    .REG_AW   (AW),
    .NUM_SRC  (NS),
    .LONG_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src_addr  (src_addr),
    .id_src_used  (src_used),
    .id_src_data  (src_data),
    .id_dest      (id_dest),
    .id_wr_en     (id_wr_en),
    .ex_dest      (ex_dest),
    .ex_wr_en     (ex_wr_en),
    .ex_long      (ex_long),
    .ex_data      (ex_data),
    .wb_dest      (wb_dest),
    .wb_wr_en     (wb_wr_en),
    .wb_data      (wb_data),
    .fwd_data     (fwd_data),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .busy         (busy)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: for each register, the EX cycle of its latest long op; result lands on WB at issue+LAT.
  bit mvalid [NREG];
  int missue [NREG];
  int mstall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_waiting(input int r);
    return mvalid[r] && (cyc < missue[r] + int'(LAT));
  endfunction

  function automatic bit m_busy();
    for (int r = 0; r < NREG; r++) begin
      if (mvalid[r] && (cyc <= missue[r] + int'(LAT))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      logic [AW-1:0] a = src_addr[i*AW +: AW];
      if (src_used[i] && ((ex_wr_en && ex_long && ex_dest == a) || m_waiting(int'(a)))) s = 1'b1;
    end
    if (id_wr_en && (m_waiting(int'(id_dest)) || (ex_wr_en && ex_long && ex_dest == id_dest)))
      s = 1'b1;
    return s;
  endfunction

  task automatic advance();
    bit s;
    s = m_stall();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) mvalid[r] = 1'b0;
      mstall_cnt = 0;
    end else begin
      if (s) mstall_cnt++;
      if (ex_wr_en && ex_long) begin
        mvalid[ex_dest] = 1'b1;
        missue[ex_dest] = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    src_addr = '0;
    src_used = '0;
    src_data = {RF1, RF0};
    id_dest  = '0;
    id_wr_en = 1'b0;
    ex_dest  = '0;
    ex_wr_en = 1'b0;
    ex_long  = 1'b0;
    ex_data  = '0;
    wb_dest  = '0;
    wb_wr_en = 1'b0;
    wb_data  = '0;
  endtask

  task automatic check_model();
    logic [31:0] e;
    logic [1:0]  s;
    for (int i = 0; i < int'(NS); i++) begin
      logic [AW-1:0] a = src_addr[i*AW +: AW];
      if (!src_used[i]) begin
        e = src_data[i*DW +: DW]; s = 2'd0;
      end else if (ex_wr_en && !ex_long && ex_dest == a) begin
        e = ex_data; s = 2'd2;
      end else if (wb_wr_en && wb_dest == a) begin
        e = wb_data; s = 2'd1;
      end else begin
        e = src_data[i*DW +: DW]; s = 2'd0;
      end
      chk($sformatf("rand_data%0d", i), fwd_data[i*DW +: DW], e);
      chk($sformatf("rand_sel%0d", i), 32'(fwd_sel[2*i +: 2]), 32'(s));
    end
    chk("rand_stall", 32'(stall), 32'(m_stall()));
    chk("rand_busy", 32'(busy), 32'(m_busy()));
`ifdef HAZ_STALL_CNT_EN
    chk("rand_stall_cycles", stall_cycles, mstall_cnt);
`endif
  endtask

  typedef struct {
    string       name;
    logic [3:0]  a0, a1;
    logic [1:0]  used;
    logic        ex_wr, ex_lg;
    logic [3:0]  ex_d;
    logic [31:0] ex_v;
    logic        wb_wr;
    logic [3:0]  wb_d;
    logic [31:0] wb_v;
    logic        id_wr;
    logic [3:0]  id_d;
    logic [31:0] e0, e1;
    logic [1:0]  s0, s1;
    logic        est;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] a0, a1, input logic [1:0] u,
                              input logic xw, xl, input logic [3:0] xd, input logic [31:0] xv,
                              input logic ww, input logic [3:0] wd, input logic [31:0] wv,
                              input logic iw, input logic [3:0] idd,
                              input logic [31:0] e0, e1, input logic [1:0] s0, s1,
                              input logic st);
    vec_t v;
    v.name = n; v.a0 = a0; v.a1 = a1; v.used = u;
    v.ex_wr = xw; v.ex_lg = xl; v.ex_d = xd; v.ex_v = xv;
    v.wb_wr = ww; v.wb_d = wd; v.wb_v = wv; v.id_wr = iw; v.id_d = idd;
    v.e0 = e0; v.e1 = e1; v.s0 = s0; v.s1 = s1; v.est = st;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    for (int r = 0; r < NREG; r++) begin
      mvalid[r] = 1'b0;
      missue[r] = 0;
    end
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    advance();
    advance();

    tbl[0]  = mk("ex_fwd",      5, 0, 2'b01, 1, 0, 5, 32'h1234, 0, 0, 0,         0, 0,
                 32'h1234, RF1, 2, 0, 0);
    tbl[1]  = mk("prio_ex_wb",  1, 3, 2'b11, 1, 0, 3, 32'hAAAA, 1, 3, 32'hBBBB, 0, 0,
                 RF0, 32'hAAAA, 0, 2, 0);
    tbl[2]  = mk("prio_unused", 1, 3, 2'b01, 1, 0, 3, 32'hAAAA, 1, 3, 32'hBBBB, 0, 0,
                 RF0, RF1, 0, 0, 0);
    tbl[3]  = mk("wb_fwd",      6, 2, 2'b11, 0, 0, 0, 32'h0,    1, 6, 32'hBBBB, 0, 0,
                 32'hBBBB, RF1, 1, 0, 0);
    tbl[4]  = mk("long_ex_raw", 6, 6, 2'b11, 1, 1, 6, 32'hDEAD, 1, 6, 32'hBBBB, 0, 0,
                 32'hBBBB, 32'hBBBB, 1, 1, 1);
    tbl[5]  = mk("r0_fwd",      0, 0, 2'b11, 1, 0, 0, 32'h77,   1, 0, 32'h88,   0, 0,
                 32'h77, 32'h77, 2, 2, 0);
    tbl[6]  = mk("ex_wr_off",   5, 0, 2'b01, 0, 0, 5, 32'h1234, 0, 0, 0,        0, 0,
                 RF0, RF1, 0, 0, 0);
    tbl[7]  = mk("waw_ex_long", 1, 2, 2'b11, 1, 1, 9, 32'h0,    0, 0, 0,        1, 9,
                 RF0, RF1, 0, 0, 1);
    tbl[8]  = mk("waw_diff",    1, 2, 2'b11, 1, 1, 9, 32'h0,    0, 0, 0,        1, 8,
                 RF0, RF1, 0, 0, 0);
    tbl[9]  = mk("unused_long", 9, 9, 2'b00, 1, 1, 9, 32'h0,    0, 0, 0,        0, 0,
                 RF0, RF1, 0, 0, 0);
    tbl[10] = mk("wb_wr_off",   6, 0, 2'b01, 0, 0, 0, 32'h0,    0, 6, 32'hBBBB, 0, 0,
                 RF0, RF1, 0, 0, 0);

    // Reset held through the table so the scoreboard stays empty between vectors.
    for (int k = 0; k < 11; k++) begin
      set_idle();
      rst      = 1'b1;
      src_addr = {tbl[k].a1, tbl[k].a0};
      src_used = tbl[k].used;
      ex_wr_en = tbl[k].ex_wr; ex_long = tbl[k].ex_lg; ex_dest = tbl[k].ex_d;
      ex_data  = tbl[k].ex_v;
      wb_wr_en = tbl[k].wb_wr; wb_dest = tbl[k].wb_d; wb_data = tbl[k].wb_v;
      id_wr_en = tbl[k].id_wr; id_dest = tbl[k].id_d;
      #1;
      chk({tbl[k].name, "_d0"},   fwd_data[31:0],  tbl[k].e0);
      chk({tbl[k].name, "_d1"},   fwd_data[63:32], tbl[k].e1);
      chk({tbl[k].name, "_s0"},   32'(fwd_sel[1:0]), 32'(tbl[k].s0));
      chk({tbl[k].name, "_s1"},   32'(fwd_sel[3:2]), 32'(tbl[k].s1));
      chk({tbl[k].name, "_stall"}, 32'(stall), 32'(tbl[k].est));
      chk({tbl[k].name, "_busy"}, 32'(busy), 32'd0);
      advance();
    end
    rst = 1'b0;

    // Long RAW on r7: stalls cycles 0..2, WB supplies the value in cycle 3.
    set_idle(); ex_wr_en = 1; ex_long = 1; ex_dest = 7; src_addr = 8'h07; src_used = 2'b01;
    #1; chk("lraw_c0_stall", 32'(stall), 1); chk("lraw_c0_busy", 32'(busy), 0);
`ifdef HAZ_STALL_CNT_EN
    chk("lraw_c0_scnt", stall_cycles, 0);
`endif
    advance();
    set_idle(); src_addr = 8'h07; src_used = 2'b01;
    #1; chk("lraw_c1_stall", 32'(stall), 1); chk("lraw_c1_busy", 32'(busy), 1);
    advance();
    #1; chk("lraw_c2_stall", 32'(stall), 1);
    advance();
    wb_wr_en = 1; wb_dest = 7; wb_data = 32'hC0DE;
    #1; chk("lraw_c3_stall", 32'(stall), 0); chk("lraw_c3_d0", fwd_data[31:0], 32'hC0DE);
    chk("lraw_c3_s0", 32'(fwd_sel[1:0]), 1); chk("lraw_c3_busy", 32'(busy), 1);
`ifdef HAZ_STALL_CNT_EN
    chk("lraw_c3_scnt", stall_cycles, 3);
`endif
    advance();
    set_idle(); src_addr = 8'h07; src_used = 2'b01;
    #1; chk("lraw_c4_busy", 32'(busy), 0); chk("lraw_c4_stall", 32'(stall), 0);
    advance();

    // WAW on r2: decode writes r2 while the long op is pending.
    set_idle(); ex_wr_en = 1; ex_long = 1; ex_dest = 2;
    #1; chk("waw_c0_stall", 32'(stall), 0);
    advance();
    set_idle(); id_wr_en = 1; id_dest = 2; src_addr = 8'h15; src_used = 2'b11;
    #1; chk("waw_c1_stall", 32'(stall), 1);
    advance();
    #1; chk("waw_c2_stall", 32'(stall), 1);
    advance();
    #1; chk("waw_c3_stall", 32'(stall), 0); chk("waw_c3_busy", 32'(busy), 1);
    advance();
    #1; chk("waw_c4_busy", 32'(busy), 0);
    advance();

    // Reset in the middle of a long op to r9.
    set_idle(); ex_wr_en = 1; ex_long = 1; ex_dest = 9;
    #1; advance();
    set_idle(); rst = 1;
    #1; chk("rst_c1_busy", 32'(busy), 1);
    advance();
    rst = 0; src_addr = 8'h09; src_used = 2'b01;
    #1; chk("rst_c2_stall", 32'(stall), 0); chk("rst_c2_busy", 32'(busy), 0);
`ifdef HAZ_STALL_CNT_EN
    chk("rst_c2_scnt", stall_cycles, 0);
`endif
    advance();

    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < int'(NS); i++) src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      src_used = NS'($urandom);
      src_data = {$urandom, $urandom};
      id_dest  = AW'($urandom_range(0, 7));
      id_wr_en = $urandom_range(0, 1) == 1;
      ex_dest  = AW'($urandom_range(0, 7));
      ex_wr_en = $urandom_range(0, 3) != 0;
      ex_long  = $urandom_range(0, 3) == 0;
      ex_data  = $urandom;
      wb_dest  = AW'($urandom_range(0, 7));
      wb_wr_en = $urandom_range(0, 1) == 1;
      wb_data  = $urandom;
      #1;
      check_model();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
